loop_replay_streamer: RTL

Read-side partner of the stream loop detector. Once a short backward-branch loop has been captured in the uop cache, this block replays it: it walks the cache read port, tags each instruction with its PC, and streams instructions to IF/ID under a valid/ready handshake while front-end fetch is blocked. On a loop-exit mispredict it flushes its in-flight work and issues a one-cycle fetch redirect to the fall-through PC.

---
 rtl/loop_pkg.sv | 23 ++
 rtl/loop_replay_queue.sv | 55 +++++
 rtl/loop_replay_streamer.sv | 136 +++++++++++++
 3 files changed

// File: rtl/loop_pkg.sv
// Shared types and constants for the loop detector / replay streamer pair.
package loop_pkg;

  localparam int unsigned DEFAULT_ADDR_WIDTH = 6;
  localparam int unsigned PC_STEP            = 4;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    EXIT
  } replay_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instruction;
  } replay_beat_t;

  // PC of the idx-th instruction after base (32-bit wrap).
  function automatic logic [31:0] pc_offset(input logic [31:0] base, input logic [31:0] idx);
    return base + idx * 32'(PC_STEP);
  endfunction

endpackage

// File: rtl/loop_replay_queue.sv
// Small FIFO of {pc, instruction} beats between the cache read pipe and IF/ID.
module loop_replay_queue
  import loop_pkg::*;
#(
  parameter int unsigned Q_DEPTH = 4,
  localparam int unsigned CW = $clog2(Q_DEPTH + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         push,
  input  replay_beat_t push_data,
  input  logic         pop,
  output replay_beat_t head,
  output logic         empty,
  output logic [CW-1:0] occupancy
);

  localparam int unsigned IW = (Q_DEPTH > 1) ? $clog2(Q_DEPTH) : 1;

  replay_beat_t  mem_q [Q_DEPTH];
  logic [IW-1:0] wr_q;
  logic [IW-1:0] rd_q;
  logic [CW-1:0] count_q;

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] idx);
    return (idx == IW'(Q_DEPTH - 1)) ? '0 : idx + IW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_q <= next_idx(wr_q);
      if (pop)  rd_q <= next_idx(rd_q);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset; count_q alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= push_data;
  end

  assign head      = mem_q[rd_q];
  assign empty     = (count_q == '0);
  assign occupancy = count_q;

endmodule

// File: rtl/loop_replay_streamer.sv
// Replays a captured loop from the uop cache to IF/ID, tagging each beat with its PC,
// and redirects fetch to the fall-through PC on loop exit.
module loop_replay_streamer
  import loop_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int unsigned Q_DEPTH    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   loop_len,
  input  logic [31:0]           loop_base_pc,
  input  logic                  mispredict,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [31:0]           rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_instruction,
  output logic [31:0]           out_pc,
  output logic                  block_fetch,
  output logic                  redirect_valid,
  output logic [31:0]           redirect_pc,
  output logic [15:0]           iter_count
);

  localparam int unsigned LW          = ADDR_WIDTH + 1;
  localparam int unsigned CACHE_DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned CW          = $clog2(Q_DEPTH + 1);

  replay_state_t         state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q;
  logic [LW-1:0]         len_q;
  logic [31:0]           base_q;
  logic [15:0]           iter_q;
  logic                  pend_q;
  logic [31:0]           pend_pc_q;

  replay_beat_t  q_head;
  logic          q_empty;
  logic [CW-1:0] q_occupancy;

  logic start_ok;
  logic last_idx;
  logic flush;

  assign start_ok = start && (loop_len != '0) && (32'(loop_len) <= CACHE_DEPTH);
  assign last_idx = ({1'b0, ptr_q} == len_q - LW'(1));
  assign flush    = (state_q == STREAM) && mispredict;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_ok) state_d = STREAM;
      STREAM:  if (mispredict) state_d = EXIT;
      EXIT:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Issue only while queue slots cover everything already in flight, so pushes never overflow.
  always_comb begin
    rd_en           = 1'b0;
    rd_addr         = '0;
    out_valid       = 1'b0;
    out_instruction = '0;
    out_pc          = '0;
    block_fetch     = 1'b0;
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
    unique case (state_q)
      STREAM: begin
        block_fetch = 1'b1;
        rd_en       = (32'(q_occupancy) + 32'(pend_q)) < Q_DEPTH;
        if (rd_en) rd_addr = ptr_q;
        out_valid = !q_empty;
        if (!q_empty) begin
          out_instruction = q_head.instruction;
          out_pc          = q_head.pc;
        end
      end
      EXIT: begin
        redirect_valid = 1'b1;
        redirect_pc    = pc_offset(base_q, 32'(len_q));
      end
      default: ;
    endcase
  end

  // Read pointer, loop bookkeeping and the one-deep read-pipe PC tag.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q     <= '0;
      len_q     <= '0;
      base_q    <= '0;
      iter_q    <= '0;
      pend_q    <= 1'b0;
      pend_pc_q <= '0;
    end else begin
      pend_q <= rd_en && !flush;
      if (rd_en) pend_pc_q <= pc_offset(base_q, 32'(ptr_q));
      if ((state_q == IDLE) && start_ok) begin
        base_q <= loop_base_pc;
        len_q  <= loop_len;
        ptr_q  <= '0;
        iter_q <= '0;
      end else if (rd_en) begin
        ptr_q <= last_idx ? '0 : ptr_q + ADDR_WIDTH'(1);
        if (last_idx && (iter_q != 16'hFFFF)) iter_q <= iter_q + 16'd1;
      end
    end
  end

  assign iter_count = iter_q;

  loop_replay_queue #(
    .Q_DEPTH(Q_DEPTH)
  ) u_queue (
    .clk       (clk),
    .reset     (reset),
    .clear     (flush),
    .push      ((state_q == STREAM) && pend_q),
    .push_data ('{pc: pend_pc_q, instruction: rd_data}),
    .pop       (out_valid && out_ready),
    .head      (q_head),
    .empty     (q_empty),
    .occupancy (q_occupancy)
  );

endmodule
